// File: rtl/vertex_fv_sequencer_pkg.sv
// Shared types and default sizing for the Vertex RS -> PE feature-vector sequencer.
package vertex_fv_sequencer_pkg;

  localparam int unsigned Max_FV_num      = 16;
  localparam int unsigned Mult_per_PE     = 4;
  localparam int unsigned Max_outstanding = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vfs_state_t;

endpackage

// File: rtl/vfs_credit_counter.sv
// Up/down credit counter for in-flight PE chunks; flags are for the upcoming count.
module vfs_credit_counter #(
  parameter int unsigned MAX_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full_next_c,
  output logic empty_next_c,
  output logic underflow_c
);

  localparam int unsigned CW = $clog2(MAX_COUNT) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // A return with nothing outstanding is flagged and leaves the count at zero.
  always_comb begin
    count_next  = count;
    underflow_c = 1'b0;
    if (inc && !dec) begin
      count_next = count + CW'(1);
    end else if (dec && !inc) begin
      if (count == '0) underflow_c = 1'b1;
      else             count_next  = count - CW'(1);
    end
  end

  assign full_next_c  = (count_next == CW'(MAX_COUNT));
  assign empty_next_c = (count_next == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end

endmodule

// File: rtl/vertex_fv_sequencer.sv
// Sweeps the RS feature-vector window in MULT_PER_PE chunks, paced by PE ready and
// limited by an in-flight credit count; pulses complete once all results are back.
module vertex_fv_sequencer
  import vertex_fv_sequencer_pkg::*;
#(
  parameter int unsigned MAX_FV_NUM      = Max_FV_num,
  parameter int unsigned MULT_PER_PE     = Mult_per_PE,
  parameter int unsigned MAX_OUTSTANDING = Max_outstanding,
  localparam int unsigned IW = $clog2(MAX_FV_NUM),
  localparam int unsigned NW = IW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [NW-1:0]          cfg_num_fv,
  input  logic                   pe_ready,
  input  logic                   pe_result_valid,
  output logic                   issue_valid,
  output logic [IW-1:0]          start_idx,
  output logic [MULT_PER_PE-1:0] lane_mask,
  output logic                   complete,
  output logic                   busy,
  output logic                   err
);

  vfs_state_t            state, state_d;
  logic                  issue_valid_d, complete_d, busy_d, err_d, go_done;
  logic [IW-1:0]         start_idx_d;
  logic [MULT_PER_PE-1:0] lane_mask_d;
  logic [NW-1:0]         num_fv, num_fv_d;
  logic [NW-1:0]         cfg_clamp_c, next_base_c;
  logic                  accept_c, last_chunk_c;
  logic                  full_next_c, empty_next_c, underflow_c;

  function automatic logic [MULT_PER_PE-1:0] chunk_mask(input logic [NW-1:0] base,
                                                        input logic [NW-1:0] num);
    logic [NW:0] idx;
    chunk_mask = '0;
    for (int i = 0; i < int'(MULT_PER_PE); i++) begin
      idx           = (NW+1)'(base) + (NW+1)'(i);
      chunk_mask[i] = (idx < (NW+1)'(num));
    end
  endfunction

  assign cfg_clamp_c  = (cfg_num_fv > NW'(MAX_FV_NUM)) ? NW'(MAX_FV_NUM) : cfg_num_fv;
  assign accept_c     = issue_valid && pe_ready;
  assign next_base_c  = NW'(start_idx) + NW'(MULT_PER_PE);
  assign last_chunk_c = (next_base_c >= num_fv);

  vfs_credit_counter #(
    .MAX_COUNT(MAX_OUTSTANDING)
  ) u_credit (
    .clk         (clk),
    .reset       (reset),
    .inc         (accept_c),
    .dec         (pe_result_valid),
    .full_next_c (full_next_c),
    .empty_next_c(empty_next_c),
    .underflow_c (underflow_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    issue_valid_d = issue_valid;
    start_idx_d   = start_idx;
    lane_mask_d   = lane_mask;
    complete_d    = 1'b0;
    busy_d        = busy;
    err_d         = err | underflow_c;
    num_fv_d      = num_fv;
    go_done       = 1'b0;

    if (fire && state != IDLE) err_d = 1'b1;

    case (state)
      IDLE: begin
        if (fire) begin
          num_fv_d    = cfg_clamp_c;
          start_idx_d = '0;
          if (cfg_num_fv > NW'(MAX_FV_NUM)) err_d = 1'b1;
          if (cfg_clamp_c == '0) begin
            go_done = 1'b1;
          end else begin
            state_d       = ISSUE;
            issue_valid_d = 1'b1;
            busy_d        = 1'b1;
            lane_mask_d   = chunk_mask('0, cfg_clamp_c);
          end
        end
      end
      ISSUE: begin
        issue_valid_d = !full_next_c;
        if (accept_c) begin
          if (last_chunk_c) begin
            issue_valid_d = 1'b0;
            if (empty_next_c) go_done = 1'b1;
            else              state_d = DRAIN;
          end else begin
            start_idx_d = IW'(next_base_c);
            lane_mask_d = chunk_mask(next_base_c, num_fv);
          end
        end
      end
      DRAIN: begin
        if (empty_next_c) go_done = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (go_done) begin
      state_d       = DONE;
      complete_d    = 1'b1;
      busy_d        = 1'b0;
      issue_valid_d = 1'b0;
      start_idx_d   = '0;
      lane_mask_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      issue_valid <= 1'b0;
      start_idx   <= '0;
      lane_mask   <= '0;
      complete    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      num_fv      <= '0;
    end else begin
      state       <= state_d;
      issue_valid <= issue_valid_d;
      start_idx   <= start_idx_d;
      lane_mask   <= lane_mask_d;
      complete    <= complete_d;
      busy        <= busy_d;
      err         <= err_d;
      num_fv      <= num_fv_d;
    end
  end

endmodule

// File: tb/tb_vertex_fv_sequencer.sv
// Randomized bench for vertex_fv_sequencer against a chunk/credit-count reference model.
module tb_vertex_fv_sequencer;

  localparam int FVN = 32;
  localparam int MPP = 4;
  localparam int MO  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fire = 1'b0;
  logic [5:0] cfg_num_fv = '0;
  logic       pe_ready = 1'b0;
  logic       pe_result_valid = 1'b0;
  logic       issue_valid;
  logic [4:0] start_idx;
  logic [3:0] lane_mask;
  logic       complete;
  logic       busy;
  logic       err;

  vertex_fv_sequencer #(
    .MAX_FV_NUM     (FVN),
    .MULT_PER_PE    (MPP),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fire           (fire),
    .cfg_num_fv     (cfg_num_fv),
    .pe_ready       (pe_ready),
    .pe_result_valid(pe_result_valid),
    .issue_valid    (issue_valid),
    .start_idx      (start_idx),
    .lane_mask      (lane_mask),
    .complete       (complete),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int n_cmp_seen = 0;
  int cyc = 0;

  // Reference model: sweep in terms of chunks issued and results outstanding.
  bit m_active = 0;
  bit m_cmp    = 0;
  bit m_err    = 0;
  int m_num    = 0;
  int m_chunks = 0;
  int m_k      = 0;
  int m_o      = 0;
  int m_due[$];

  int ready_pct = 100;
  int res_mode  = 0;   // 0: return when due, 1: withhold, 2: release one then withhold
  int dly_min   = 2;
  int dly_max   = 2;
  bit stray     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input int base, input int num);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (base + i < num);
    return m;
  endfunction

  task automatic step(input bit f, input int cfg);
    int  e_iv, e_si, e_cmp, e_busy;
    logic [3:0] e_lm;
    bit  chk_lm, rdy, ret, acc, idle_now, nxt_cmp;
    @(negedge clk);
    e_iv = 0; e_si = 0; e_cmp = 0; e_busy = 0; e_lm = '0; chk_lm = 1;
    if (m_cmp) begin
      e_cmp = 1;
    end else if (m_active) begin
      e_busy = 1;
      if (m_k < m_chunks) begin
        e_iv = (m_o < MO) ? 1 : 0;
        e_si = MPP * m_k;
        e_lm = exp_mask(MPP * m_k, m_num);
      end else begin
        e_si   = MPP * (m_chunks - 1);
        chk_lm = 0;
      end
    end
    chk("issue_valid", 32'(issue_valid), e_iv);
    chk("start_idx",   32'(start_idx),   e_si);
    if (chk_lm) chk("lane_mask", 32'(lane_mask), 32'(e_lm));
    chk("complete",    32'(complete),    e_cmp);
    chk("busy",        32'(busy),        e_busy);
    chk("err",         32'(err),         32'(m_err));
    if (complete === 1'b1) n_cmp_seen++;

    rdy = ($urandom_range(0, 99) < ready_pct);
    ret = 0;
    if (stray) begin
      ret = 1;
    end else if (m_due.size() > 0 && res_mode != 1 && (res_mode == 2 || m_due[0] <= cyc)) begin
      ret = 1;
      void'(m_due.pop_front());
      if (res_mode == 2) res_mode = 1;
    end
    fire            = f;
    cfg_num_fv      = 6'(cfg);
    pe_ready        = rdy;
    pe_result_valid = ret;
    @(posedge clk);

    idle_now = !m_active && !m_cmp;
    acc = m_active && (m_k < m_chunks) && (m_o < MO) && rdy;
    if (ret && m_o == 0 && !acc) m_err = 1;
    else m_o = m_o + int'(acc) - int'(ret);
    if (acc) begin
      m_k++;
      m_due.push_back(cyc + $urandom_range(dly_min, dly_max));
    end
    nxt_cmp = 0;
    if (m_active && m_k == m_chunks && m_o == 0) begin
      m_active = 0;
      nxt_cmp  = 1;
    end
    if (f) begin
      if (!idle_now) begin
        m_err = 1;
      end else begin
        if (cfg > FVN) m_err = 1;
        m_num    = (cfg > FVN) ? FVN : cfg;
        m_chunks = (m_num + MPP - 1) / MPP;
        m_k      = 0;
        if (m_chunks == 0) nxt_cmp = 1;
        else m_active = 1;
      end
    end
    m_cmp = nxt_cmp;
    cyc++;
  endtask

  task automatic finish_sweep();
    int seen0 = n_cmp_seen;
    int guard = 0;
    while ((m_active || m_cmp) && guard < 500) begin
      step(0, 0);
      guard++;
    end
    chk("one_complete", n_cmp_seen - seen0, 1);
  endtask

  task automatic run_sweep(input int num);
    step(1, num);
    finish_sweep();
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    #2;
    reset           = 1'b0;
    fire            = 1'b0;
    pe_ready        = 1'b0;
    pe_result_valid = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_start_idx",   32'(start_idx),   0);
    chk("rst_lane_mask",   32'(lane_mask),   0);
    chk("rst_complete",    32'(complete),    0);
    chk("rst_busy",        32'(busy),        0);
    chk("rst_err",         32'(err),         0);
    m_active = 0; m_cmp = 0; m_err = 0; m_k = 0; m_o = 0; m_chunks = 0;
    m_due.delete();
    res_mode = 0;
    stray    = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_issue_valid", 32'(issue_valid), 0);
    chk("por_start_idx",   32'(start_idx),   0);
    chk("por_lane_mask",   32'(lane_mask),   0);
    chk("por_busy",        32'(busy),        0);
    chk("por_err",         32'(err),         0);
    reset = 1'b1;

    // Full window, fixed 2-cycle result latency
    ready_pct = 100; dly_min = 2; dly_max = 2;
    run_sweep(16);
    chk("t1_err", 32'(err), 0);

    // Partial last chunk
    run_sweep(6);

    // Empty window: complete one cycle after fire, never busy
    run_sweep(0);

    // Credit limit: 8 chunks with results withheld, then release one
    res_mode = 1;
    step(1, 32);
    repeat (6) step(0, 0);
    chk("t4_stalled", 32'(issue_valid), 0);
    res_mode = 2;
    step(0, 0);
    step(0, 0);
    repeat (2) step(0, 0);
    res_mode = 0; dly_min = 1; dly_max = 3;
    finish_sweep();

    // Random PE backpressure and result latency
    ready_pct = 50; dly_min = 1; dly_max = 4;
    for (int s = 0; s < 6; s++) run_sweep($urandom_range(1, 32));
    ready_pct = 70; dly_min = 1; dly_max = 2;
    for (int s = 0; s < 4; s++) run_sweep($urandom_range(1, 32));
    chk("t5_err", 32'(err), 0);

    // Stray result in IDLE sets the sticky error
    ready_pct = 100;
    stray = 1;
    step(0, 0);
    stray = 0;
    repeat (2) step(0, 0);
    chk("stray_err", 32'(err), 1);
    do_reset();

    // Fire during ISSUE is ignored, then reset mid-sweep
    res_mode = 1;
    step(1, 32);
    step(0, 0);
    step(1, 8);
    repeat (3) step(0, 0);
    chk("fire_busy_err", 32'(err), 1);
    do_reset();
    repeat (2) step(0, 0);

    // Restart after reset, then clamp an oversize count
    res_mode = 0; dly_min = 1; dly_max = 3;
    run_sweep(12);
    chk("restart_err", 32'(err), 0);
    run_sweep(40);
    chk("clamp_err", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
